// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory bus between pc_fetch_unit (master) and instruction memory (slave).
// The master issues a word-address read; the slave answers with data once busywait drops.
interface pc_fetch_unit_if;
  logic        imem_read;
  logic [29:0] imem_addr;
  logic        imem_busywait;
  logic [31:0] imem_data;

  modport master (
    output imem_read,
    output imem_addr,
    input  imem_busywait,
    input  imem_data
  );

  modport slave (
    input  imem_read,
    input  imem_addr,
    output imem_busywait,
    output imem_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / instruction fetch unit: IDLE -> FETCH -> ISSUE loop, at most one instruction per 2 cycles.
// Optional stall counter built when PC_FETCH_STALLCNT_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            jump_target,
  input  logic                   flow_sel,
  input  logic                   busywait_in,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            instruction,
  output logic                   instr_valid
`ifdef PC_FETCH_STALLCNT_EN
  ,
  output logic [15:0]            stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        read_req;
  logic        valid;
  logic        fetch_done;
  logic        issue_exit;
  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  logic [31:0] pc_jump;
  logic [31:0] instruction_next;
  logic        unused_target_bits;

  // Low target bits are discarded so the PC stays word aligned.
  assign pc_seq             = pc + 32'd4;
  assign pc_jump            = {jump_target[31:2], 2'b00};
  assign unused_target_bits = ^jump_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    read_req         = 1'b0;
    valid            = 1'b0;
    fetch_done       = 1'b0;
    issue_exit       = 1'b0;
    pc_next          = pc;
    instruction_next = instruction;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        read_req = 1'b1;
        if (!imem.imem_busywait) begin
          fetch_done       = 1'b1;
          instruction_next = imem.imem_data;
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        valid = 1'b1;
        if (!busywait_in) begin
          issue_exit = 1'b1;
          pc_next    = flow_sel ? pc_jump : pc_seq;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= {RESET_PC[31:2], 2'b00};
      instruction <= 32'h0000_0000;
    end else begin
      pc          <= pc_next;
      instruction <= instruction_next;
    end
  end

  assign imem.imem_read = read_req;
  assign imem.imem_addr = pc[31:2];
  assign instr_valid    = valid;

`ifdef PC_FETCH_STALLCNT_EN
  logic stall_event;

  // Counts every edge lost to a memory wait or a CPU stall; holds at all-ones.
  assign stall_event = (state == FETCH && imem.imem_busywait) ||
                       (state == ISSUE && busywait_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'h0000;
    end else if (stall_event && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

  // Structural invariants of the fetch loop.
  a_pc_aligned: assert property (@(posedge clk) pc[1:0] == 2'b00);
  a_read_valid_exclusive: assert property (@(posedge clk) !(read_req && valid));
  a_fetch_addr_stable: assert property (@(posedge clk)
    (!reset && state == FETCH && imem.imem_busywait) |=> (imem.imem_read && $stable(imem.imem_addr)));
  a_issue_hold: assert property (@(posedge clk)
    (!reset && state == ISSUE && busywait_in) |=> ($stable(pc) && $stable(instruction) && valid));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random stimulus,
// all compared against a transaction-level reference model of the fetch loop.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] jump_target;
  logic        flow_sel;
  logic        busywait_in;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;
`ifdef PC_FETCH_STALLCNT_EN
  logic [15:0] stall_count;
`endif

  pc_fetch_unit_if imem_bus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .jump_target (jump_target),
    .flow_sel    (flow_sel),
    .busywait_in (busywait_in),
    .imem        (imem_bus.master),
    .pc          (pc),
    .instruction (instruction),
    .instr_valid (instr_valid)
`ifdef PC_FETCH_STALLCNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: where the unit should be, which PC it owns, what it last fetched.
  typedef enum {M_IDLE, M_FETCH, M_ISSUE} phase_t;
  phase_t      m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_stall;

  function automatic logic [31:0] memWord(input logic [29:0] waddr);
    logic [31:0] w;
    w = {2'b00, waddr};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("imem_read", {31'b0, imem_bus.imem_read}, {31'b0, m_phase == M_FETCH});
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == M_ISSUE});
    checkOutput("pc", pc, m_pc);
    checkOutput("imem_addr", {2'b00, imem_bus.imem_addr}, {2'b00, m_pc[31:2]});
    checkOutput("instruction", instruction, m_instr);
`ifdef PC_FETCH_STALLCNT_EN
    checkOutput("stall_count", {16'b0, stall_count}, 32'(m_stall));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, check after the next edge.
  task automatic applyStimulus(input logic r, input logic imb, input logic cb,
                               input logic fs, input logic [31:0] jt);
    reset                  = r;
    imem_bus.imem_busywait = imb;
    busywait_in            = cb;
    flow_sel               = fs;
    jump_target            = jt;
    if (imem_bus.imem_read && !imb)
      imem_bus.imem_data = memWord(imem_bus.imem_addr);
    else
      imem_bus.imem_data = $urandom;

    if (r) begin
      m_phase = M_IDLE;
      m_pc    = {RESET_PC[31:2], 2'b00};
      m_instr = 32'h0;
      m_stall = 0;
    end else begin
      case (m_phase)
        M_IDLE:  m_phase = M_FETCH;
        M_FETCH: begin
          if (imb) begin
            if (m_stall < 65535) m_stall = m_stall + 1;
          end else begin
            m_instr = memWord(m_pc[31:2]);
            m_phase = M_ISSUE;
          end
        end
        M_ISSUE: begin
          if (cb) begin
            if (m_stall < 65535) m_stall = m_stall + 1;
          end else begin
            m_pc    = fs ? {jt[31:2], 2'b00} : m_pc + 32'd4;
            m_phase = M_FETCH;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end

    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    reset                  = 1'b1;
    imem_bus.imem_busywait = 1'b0;
    imem_bus.imem_data     = 32'h0;
    busywait_in            = 1'b0;
    flow_sel               = 1'b0;
    jump_target            = 32'h0;
    m_phase                = M_IDLE;
    m_pc                   = RESET_PC;
    m_instr                = 32'h0;
    m_stall                = 0;

    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("reset_pc", pc, 32'h0000_0000);
    checkOutput("reset_instr", instruction, 32'h0000_0000);

    // Sequential flow from reset, then a two-cycle CPU stall at PC=4.
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("first_fetch_read", {31'b0, imem_bus.imem_read}, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("issue_pc4", pc, 32'h0000_0004);
    applyStimulus(0, 0, 1, 1, 32'h0000_0100);
    applyStimulus(0, 0, 1, 0, 32'h0);
    checkOutput("stall_valid_held", {31'b0, instr_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("after_stall_pc8", pc, 32'h0000_0008);

    // Memory wait of three cycles at PC=8.
    applyStimulus(0, 1, 1, 1, 32'h0000_0200);
    applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("wait_addr", {2'b00, imem_bus.imem_addr}, 32'd2);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("fetch_pc10", pc, 32'h0000_0010);

    // Branch: flow_sel pulsed during FETCH is ignored, honoured at ISSUE exit.
    applyStimulus(0, 0, 0, 1, 32'h0000_0080);
    applyStimulus(0, 0, 0, 1, 32'h0000_0043);
    checkOutput("branch_pc", pc, 32'h0000_0040);

    // Wrap: jump to the last word, then fall through to zero.
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF);
    checkOutput("top_pc", pc, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);
    checkOutput("wrap_pc", pc, 32'h0000_0000);

    // Reset while a fetch at 0x20 is stalled by memory.
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0022);
    applyStimulus(0, 1, 0, 0, 32'h0);
    checkOutput("midfetch_pc", pc, 32'h0000_0020);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("abort_read", {31'b0, imem_bus.imem_read}, 32'd0);
    checkOutput("abort_pc", pc, RESET_PC);
    applyStimulus(0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0);

    // Randomized traffic with occasional resets and targets near the top of memory.
    for (int i = 0; i < 3000; i++) begin
      logic        r, imb, cb, fs;
      logic [31:0] jt;
      r   = ($urandom_range(0, 99) < 2);
      imb = ($urandom_range(0, 99) < 30);
      cb  = ($urandom_range(0, 99) < 30);
      fs  = ($urandom_range(0, 99) < 25);
      jt  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      applyStimulus(r, imb, cb, fs, jt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
